safe_unlock_sequencer: RTL and testbench

Top-level controller for the safe's multi-stage unlock puzzle. It enables the stage detectors (knock, tilt, and others) one at a time in a fixed order and enforces a per-stage timeout. It drives the single electromagnet hold line and counts failed attempts, with an optional lockout penalty. It sits between the board-level arm input and the individual stage blocks, which report success on their `stage_done` lines.

---
 rtl/safe_pkg.sv | 18 +
 rtl/safe_unlock_sequencer_ms_timer.sv | 47 ++++
 rtl/safe_unlock_sequencer.sv | 174 +++++++++++++++++
 tb/tb_safe_unlock_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/safe_pkg.sv
// Shared types and width helpers for the safe unlock sequencer.
package safe_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_GAP     = 3'd2,
      S_OPEN    = 3'd3,
      S_LOCKOUT = 3'd4
   } seq_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/safe_unlock_sequencer_ms_timer.sv
// Millisecond down-counter: CLKS_PER_MS prescaler feeding a ms counter that
// is loaded on restart; expired pulses for one cycle at terminal count.
module ms_timer #(
   parameter int CLKS_PER_MS = 50_000,
   parameter int MS_W        = 16
) (
   input  logic            CLOCK_50,
   input  logic            reset,
   input  logic            restart,
   input  logic [MS_W-1:0] limit_ms,
   output logic            expired
);
   localparam int PRE_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

   logic [PRE_W-1:0] r_pre;
   logic [MS_W-1:0]  r_ms;
   logic             r_run;
   logic             w_pre_tc;
   logic             w_tc;

   assign w_pre_tc = (r_pre == '0);
   assign w_tc     = r_run && w_pre_tc && (r_ms == '0);
   assign expired  = w_tc;

   // Loading limit-1 / CLKS-1 makes terminal count land exactly limit*CLKS edges after restart.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_pre <= '0;
         r_ms  <= '0;
         r_run <= 1'b0;
      end else if (restart) begin
         r_pre <= PRE_W'(CLKS_PER_MS - 1);
         r_ms  <= limit_ms - 1'b1;
         r_run <= 1'b1;
      end else if (w_tc) begin
         r_run <= 1'b0;
      end else if (r_run) begin
         if (w_pre_tc) begin
            r_pre <= PRE_W'(CLKS_PER_MS - 1);
            r_ms  <= r_ms - 1'b1;
         end else begin
            r_pre <= r_pre - 1'b1;
         end
      end
   end

endmodule

// File: rtl/safe_unlock_sequencer.sv
// Unlock puzzle sequencer: walks the stages in order with a per-stage timeout,
// drives the magnet, counts failures. SAFE_SEQ_LOCKOUT_EN adds the lockout penalty.
//
//   state   | meaning
//   IDLE    | all stages disabled, magnet held, waiting for arm
//   RUN     | one stage enabled, timer running
//   GAP     | one cycle with all enables low before the next stage
//   OPEN    | magnet released for HOLD_MS, arm ignored
//   LOCKOUT | penalty after MAX_FAILS timeouts, arm ignored
module safe_unlock_sequencer
   import safe_pkg::*;
#(
   parameter int NUM_STAGES  = 3,
   parameter int CLKS_PER_MS = 50_000,
   parameter int TIMEOUT_MS  = 10_000,
   parameter int HOLD_MS     = 5_000,
   parameter int MAX_FAILS   = 3,
   parameter int LOCKOUT_MS  = 30_000
) (
   input  logic                              CLOCK_50,
   input  logic                              reset,
   input  logic                              arm,
   input  logic [NUM_STAGES-1:0]             stage_done,
   output logic [NUM_STAGES-1:0]             stage_enable,
   output logic [$clog2(NUM_STAGES)-1:0]     stage_idx,
   output logic                              elmag_hold,
   output logic                              open_flag,
   output logic [$clog2(MAX_FAILS+1)-1:0]    fail_count,
   output logic                              locked_out
);
   localparam int IDX_W  = $clog2(NUM_STAGES);
   localparam int FAIL_W = $clog2(MAX_FAILS + 1);
   localparam int MS_W   = $clog2(max3(TIMEOUT_MS, HOLD_MS, LOCKOUT_MS) + 1);
   localparam logic [NUM_STAGES-1:0] ENA_LSB = NUM_STAGES'(1);

   seq_state_t        r_state;
   logic [IDX_W-1:0]  r_idx;
   logic [FAIL_W-1:0] r_fails;
   logic [NUM_STAGES-1:0] r_stage_enable;
   logic [IDX_W-1:0]  r_stage_idx;
   logic              r_elmag_hold;
   logic              r_open_flag;
   logic [FAIL_W-1:0] r_fail_count;

   logic              w_done_act;
   logic              w_last;
   logic              w_expired;
   logic              w_restart;
   logic [MS_W-1:0]   w_limit;
   logic [FAIL_W-1:0] w_fails_inc;

   assign w_done_act  = stage_done[r_idx];
   assign w_last      = (r_idx == IDX_W'(NUM_STAGES - 1));
   assign w_fails_inc = (r_fails == FAIL_W'(MAX_FAILS)) ? r_fails : r_fails + 1'b1;

`ifdef SAFE_SEQ_LOCKOUT_EN
   logic w_lock_trip;
   logic r_locked_out;
   assign w_lock_trip = (w_fails_inc == FAIL_W'(MAX_FAILS));
   assign locked_out  = r_locked_out;
`else
   assign locked_out  = 1'b0;
`endif

   // Timer is reloaded on the same edge that enters RUN, OPEN or LOCKOUT.
   always_comb begin
      w_restart = 1'b0;
      w_limit   = MS_W'(TIMEOUT_MS);
      case (r_state)
         S_IDLE: w_restart = arm;
         S_GAP:  w_restart = 1'b1;
         S_RUN: begin
            if (arm && w_done_act && w_last) begin
               w_restart = 1'b1;
               w_limit   = MS_W'(HOLD_MS);
            end
`ifdef SAFE_SEQ_LOCKOUT_EN
            else if (arm && !w_done_act && w_expired && w_lock_trip) begin
               w_restart = 1'b1;
               w_limit   = MS_W'(LOCKOUT_MS);
            end
`endif
         end
         default: ;
      endcase
   end

   ms_timer #(
      .CLKS_PER_MS (CLKS_PER_MS),
      .MS_W        (MS_W)
   ) u_timer (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .restart  (w_restart),
      .limit_ms (w_limit),
      .expired  (w_expired)
   );

   // Outputs are a registered decode of the current state, one edge behind it.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_idx          <= '0;
         r_fails        <= '0;
         r_stage_enable <= '0;
         r_stage_idx    <= '0;
         r_elmag_hold   <= 1'b1;
         r_open_flag    <= 1'b0;
         r_fail_count   <= '0;
`ifdef SAFE_SEQ_LOCKOUT_EN
         r_locked_out   <= 1'b0;
`endif
      end else begin
         r_stage_enable <= (r_state == S_RUN) ? (ENA_LSB << r_idx) : '0;
         r_stage_idx    <= r_idx;
         r_elmag_hold   <= (r_state != S_OPEN);
         r_open_flag    <= (r_state == S_OPEN);
         r_fail_count   <= r_fails;
`ifdef SAFE_SEQ_LOCKOUT_EN
         r_locked_out   <= (r_state == S_LOCKOUT);
`endif
         case (r_state)
            S_IDLE: begin
               if (arm) begin
                  r_idx   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (!arm) begin
                  r_state <= S_IDLE;
               end else if (w_done_act) begin
                  if (w_last) begin
                     r_fails <= '0;
                     r_state <= S_OPEN;
                  end else begin
                     r_state <= S_GAP;
                  end
               end else if (w_expired) begin
                  r_fails <= w_fails_inc;
`ifdef SAFE_SEQ_LOCKOUT_EN
                  r_state <= w_lock_trip ? S_LOCKOUT : S_IDLE;
`else
                  r_state <= S_IDLE;
`endif
               end
            end
            S_GAP: begin
               r_idx   <= r_idx + 1'b1;
               r_state <= S_RUN;
            end
            S_OPEN: begin
               if (w_expired) r_state <= S_IDLE;
            end
`ifdef SAFE_SEQ_LOCKOUT_EN
            S_LOCKOUT: begin
               if (w_expired) begin
                  r_fails <= '0;
                  r_state <= S_IDLE;
               end
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign stage_enable = r_stage_enable;
   assign stage_idx    = r_stage_idx;
   assign elmag_hold   = r_elmag_hold;
   assign open_flag    = r_open_flag;
   assign fail_count   = r_fail_count;

endmodule

// File: tb/tb_safe_unlock_sequencer.sv
// Scoreboard bench: directed scenarios plus random arm/done/reset traffic,
// checked cycle by cycle against a deadline-based behavioural model.
module tb_safe_unlock_sequencer;
   localparam int NS  = 3;
   localparam int CPM = 4;
   localparam int TO  = 5;
   localparam int HO  = 3;
   localparam int MF  = 2;
   localparam int LO  = 10;
`ifdef SAFE_SEQ_LOCKOUT_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       arm = 1'b0;
   logic [2:0] done = 3'b000;
   logic [2:0] en;
   logic [1:0] idx;
   logic       hold;
   logic       openf;
   logic [1:0] fc;
   logic       lk;

   always #5 clk = ~clk;

   safe_unlock_sequencer #(
      .NUM_STAGES  (NS),
      .CLKS_PER_MS (CPM),
      .TIMEOUT_MS  (TO),
      .HOLD_MS     (HO),
      .MAX_FAILS   (MF),
      .LOCKOUT_MS  (LO)
   ) dut (
      .CLOCK_50     (clk),
      .reset        (rst),
      .arm          (arm),
      .stage_done   (done),
      .stage_enable (en),
      .stage_idx    (idx),
      .elmag_hold   (hold),
      .open_flag    (openf),
      .fail_count   (fc),
      .locked_out   (lk)
   );

   typedef struct packed {
      logic [2:0] en;
      logic [1:0] idx;
      logic       hold;
      logic       opn;
      logic [1:0] fc;
      logic       lk;
   } obs_t;

   obs_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   // Model: where the safe is, which stage, failures so far, and the edge
   // number at which the current timed phase ends.
   typedef enum int {M_IDLE, M_RUN, M_GAP, M_OPEN, M_LOCK} mphase_t;
   mphase_t ph = M_IDLE;
   int stage = 0;
   int fails = 0;
   int deadline = 0;

   function automatic obs_t view();
      obs_t o;
      o.en   = (ph == M_RUN) ? 3'(1 << stage) : 3'b000;
      o.idx  = 2'(stage);
      o.hold = (ph != M_OPEN);
      o.opn  = (ph == M_OPEN);
      o.fc   = 2'(fails);
      o.lk   = (ph == M_LOCK);
      return o;
   endfunction

   task automatic model_step(input bit r, input bit a, input logic [2:0] d, input int t);
      if (r) begin
         ph = M_IDLE; stage = 0; fails = 0;
         return;
      end
      case (ph)
         M_IDLE: if (a) begin ph = M_RUN; stage = 0; deadline = t + TO*CPM; end
         M_RUN: begin
            if (!a) ph = M_IDLE;
            else if (d[stage]) begin
               if (stage == NS-1) begin ph = M_OPEN; fails = 0; deadline = t + HO*CPM; end
               else ph = M_GAP;
            end else if (t == deadline) begin
               fails = (fails < MF) ? fails + 1 : MF;
               if (LOCK_EN && fails == MF) begin ph = M_LOCK; deadline = t + LO*CPM; end
               else ph = M_IDLE;
            end
         end
         M_GAP:  begin stage = stage + 1; ph = M_RUN; deadline = t + TO*CPM; end
         M_OPEN: if (t == deadline) ph = M_IDLE;
         M_LOCK: if (t == deadline) begin fails = 0; ph = M_IDLE; end
         default: ph = M_IDLE;
      endcase
   endtask

   // Outputs after an edge reflect the model state held before that edge.
   task automatic drive(input bit r, input bit a, input logic [2:0] d, input int n);
      obs_t o;
      for (int i = 0; i < n; i++) begin
         rst = r; arm = a; done = d;
         @(posedge clk);
         cyc++;
         if (r) begin
            model_step(r, a, d, cyc);
            o = view();
         end else begin
            o = view();
            model_step(r, a, d, cyc);
         end
         exp_q.push_back(o);
         #1;
      end
   endtask

   initial begin : monitor
      obs_t e;
      obs_t g;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{en: en, idx: idx, hold: hold, opn: openf, fc: fc, lk: lk};
            vectors++;
            if (g !== e) begin
               miscompares++;
               $display("FAIL vec%0d outputs: got en=%b idx=%0d hold=%b open=%b fails=%0d lock=%b, want en=%b idx=%0d hold=%b open=%b fails=%0d lock=%b",
                        vectors, g.en, g.idx, g.hold, g.opn, g.fc, g.lk,
                        e.en, e.idx, e.hold, e.opn, e.fc, e.lk);
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [2:0] rd;
      drive(1, 0, 3'b000, 2);
      // happy path, arm ignored while open
      drive(0, 1, 3'b000, 6);
      drive(0, 1, 3'b001, 1);
      drive(0, 1, 3'b000, 6);
      drive(0, 1, 3'b010, 1);
      drive(0, 1, 3'b000, 6);
      drive(0, 1, 3'b100, 1);
      drive(0, 1, 3'b000, 5);
      drive(0, 0, 3'b000, 12);
      // two timeouts with arm held, then lockout and recovery
      drive(0, 1, 3'b000, 100);
      drive(0, 0, 3'b000, 3);
      // done coincident with timeout, then abort coincident with done
      drive(0, 1, 3'b000, 20);
      drive(0, 1, 3'b001, 1);
      drive(0, 1, 3'b000, 2);
      drive(0, 0, 3'b010, 1);
      drive(0, 0, 3'b000, 2);
      // stray done on an inactive stage
      drive(0, 1, 3'b000, 2);
      drive(0, 1, 3'b100, 3);
      drive(0, 0, 3'b000, 2);
      // reset in the middle of the open hold
      drive(0, 1, 3'b000, 3);
      drive(0, 1, 3'b001, 1);
      drive(0, 1, 3'b000, 2);
      drive(0, 1, 3'b010, 1);
      drive(0, 1, 3'b000, 2);
      drive(0, 1, 3'b100, 1);
      drive(0, 1, 3'b000, 4);
      drive(1, 1, 3'b000, 1);
      drive(0, 0, 3'b000, 3);
      // random traffic
      for (int i = 0; i < 2500; i++) begin
         for (int b = 0; b < 3; b++) rd[b] = ($urandom_range(0, 11) == 0);
         drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 96), rd, 1);
      end
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
